fb_sdram_reader: RTL and testbench
==================================

# fb_sdram_reader

Frame-buffer scan-out master for the secondary SDRAM host port of the Wishbone SDRAM controller. It walks a linear 16-bit-word frame buffer from a programmable base address and issues pipelined read requests on the `sdr_*` port. Returned words are buffered in an internal FIFO and presented to the video pipeline as a valid/ready pixel stream. It sits between the SDRAM controller's secondary port and the display timing/pixel-output logic, all in the SDRAM clock domain.

## Interface
- `ADDR_W`, 22: SDRAM word-address width.
- `FIFO_DEPTH`, 64: pixel FIFO depth in 16-bit words, power of two, ≥4.
- `OUTS_W`, 3: width of the outstanding-read counter; maximum in-flight reads is 2^OUTS_W−1.

- `clk` in 1: single clock; SDRAM clock domain.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: scan-out enable, sampled every cycle.
- `frame_start` in 1: one-cycle pulse marking the start of a frame.
- `fb_base` in ADDR_W: frame-buffer base word address, latched on `frame_start`.
- `fb_words` in ADDR_W: words per frame, latched on `frame_start`; 0 means fetch nothing.
- `px_data` out 16: head-of-FIFO word (first-word fall-through).
- `px_valid` out 1: FIFO not empty.
- `px_ready` in 1: consumer pop.
- `sdr_rd` out 1: read request.
- `sdr_wr` out 1: constant 0.
- `sdr_hAddr` out 22: request address.
- `sdr_hDIn` out 16: constant 0.
- `sdr_earlyOpBegun` in 1: request accepted in this cycle (combinational).
- `sdr_opBegun`, `sdr_rdPending`, `sdr_done` in 1: monitored only; unused in logic.
- `sdr_rdDone` in 1: read data valid on `sdr_hDOut`.
- `sdr_hDOut` in 16: read data.
- `underrun` out 1: sticky underrun flag.
- `underrun_cnt` out 16: saturating underrun count.

## Operation
- States: S_IDLE, S_FETCH, S_DONE, S_FLUSH.
- **S_IDLE:** `frame_start` with `enable`=1 latches `fb_base`/`fb_words`, sets `addr` to `fb_base` and `remaining` to `fb_words`, then moves to S_FETCH, or to S_DONE if `fb_words`=0.
- **S_FETCH:**
  - `sdr_rd` = `can_issue` = (`remaining`≠0) & (`fifo_count`+`outstanding` < FIFO_DEPTH) & (`outstanding` < 2^OUTS_W−1).
  - `sdr_hAddr` = `addr`.
  - Accept = `sdr_rd` & `sdr_earlyOpBegun`. Accept increments `addr` and `outstanding` and decrements `remaining`.
  - When `remaining` reaches 0, go to S_DONE.
- **S_DONE:** no requests are issued; in-flight data is still written to the FIFO.
- **`sdr_rdDone`:** decrements `outstanding`. The data is written to the FIFO unless the state is S_FLUSH.
- **Simultaneous accept and `rdDone`:** `outstanding` is unchanged.
- **`frame_start` in S_FETCH or S_DONE:**
  - If `outstanding`=0: flush the FIFO, reload the address and word count, and re-enter S_FETCH the next cycle.
  - Otherwise go to S_FLUSH.
- **S_FLUSH:**
  - `sdr_rd`=0; returning data is discarded; the FIFO is held empty.
  - When `outstanding`=0, use the values latched at that `frame_start` to enter S_FETCH, or S_DONE if the count was 0.
- **`enable`=0 in any state:** behaves like an abort with no restart. It drains through S_FLUSH, then goes to S_IDLE.
- **Pixel stream:** a pop occurs on `px_valid` & `px_ready`. A FIFO write and a pop in the same cycle leave `fifo_count` unchanged.
- **Address arithmetic:** `addr` wraps modulo 2^ADDR_W; no bounds check is applied.

## Timing
- **Reset values:**
  - state S_IDLE; `sdr_rd`=0; `sdr_hAddr`=0.
  - `outstanding`=0; `fifo_count`=0.
  - `px_valid`=0; `px_data`=0.
  - `underrun`=0; `underrun_cnt`=0.
  - Reset mid-frame abandons in-flight reads. The controller must also be reset.
- **Request timing:**
  - `sdr_rd` and `sdr_hAddr` are driven from registered state. They are combinational only through `can_issue`, which depends on registered counters.
  - They are held stable until accepted.
- **Frame-start latency:**
  - First `sdr_rd` appears 1 cycle after `frame_start`.
  - The first pixel appears with `px_valid`=1 one cycle after the first `sdr_rdDone`.
- **Throughput:** one accept per cycle is allowed back-to-back.

## Configuration
- `FB_READER_UNDERRUN_EN` defined:
  - An underrun is `px_ready` & ~`px_valid` in S_FETCH or S_DONE while `outstanding`+`remaining`≠0.
  - On an underrun, `underrun` sets and `underrun_cnt` increments, saturating at 0xFFFF.
  - Both clear only on `reset`.
- Not defined: `underrun` and `underrun_cnt` are tied to 0 and no counter logic is built.

## Structure
- Package `fb_reader_pkg`:
  - `fb_state_t` enum: S_IDLE, S_FETCH, S_DONE, S_FLUSH.
  - Localparam `FB_UNDERRUN_MAX` = 16'hFFFF.
- Sub-module `fb_line_fifo`:
  - First-word-fall-through synchronous FIFO (DEPTH, WIDTH=16).
  - Ports: `count`, synchronous `flush`.
- Top level: FSM, address/remaining counters, outstanding counter, credit logic.

## Test plan
- **Basic frame:** controller model with 3-cycle read latency, always-accepting `earlyOpBegun`; `fb_base`=0x100, `fb_words`=8, `px_ready`=1 -> addresses 0x100..0x107 issued in order; `px_data` = model contents in order; state ends in S_DONE.
- **Backpressure:** `fb_words`=200, FIFO_DEPTH=64, `px_ready`=0 -> requests stop with `fifo_count`+`outstanding`=64. Never more than 64 words are accepted; releasing `px_ready` resumes fetching.
- **Stalled accept:** `earlyOpBegun` withheld for 5 cycles -> `sdr_rd` and `sdr_hAddr` held constant; no address skipped.
- **Mid-frame restart:** `frame_start` with 4 reads outstanding -> S_FLUSH, no FIFO writes from the 4 returns. The next request is the new `fb_base`, and the first pixel is new-frame word 0.
- **Wrap and zero:** `fb_base`=0x3FFFFE, `fb_words`=4 -> addresses 0x3FFFFE, 0x3FFFFF, 0x000000, 0x000001. A frame with `fb_words`=0 issues no `sdr_rd`.
- **Underrun (macro on):** `px_ready`=1 with read latency 10 -> `underrun`=1 and `underrun_cnt` equals the number of empty pop cycles. With the macro off, both stay 0.

Source files
------------

// File: rtl/fb_reader_pkg.sv
// Shared types and constants for the frame-buffer SDRAM reader.
package fb_reader_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2,
        S_FLUSH = 2'd3
    } fb_state_t;

    localparam logic [15:0] FB_UNDERRUN_MAX = 16'hFFFF;

endpackage

// File: rtl/fb_line_fifo.sv
// First-word-fall-through pixel FIFO with synchronous flush.
// rd_data shows the head word while count != 0, otherwise 0.
module fb_line_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign w_wr    = wr_en && (r_count != FULL);
    assign w_rd    = rd_en && (r_count != '0);
    assign count   = r_count;
    assign rd_data = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

    // Pointer and occupancy tracking; flush empties the FIFO in one cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/fb_sdram_reader.sv
// Frame-buffer scan-out master on the secondary SDRAM host port.
// Optional underrun monitor built when FB_READER_UNDERRUN_EN is defined.
module fb_sdram_reader
    import fb_reader_pkg::*;
#(
    parameter int ADDR_W     = 22,
    parameter int FIFO_DEPTH = 64,
    parameter int OUTS_W     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              frame_start,
    input  logic [ADDR_W-1:0] fb_base,
    input  logic [ADDR_W-1:0] fb_words,
    output logic [15:0]       px_data,
    output logic              px_valid,
    input  logic              px_ready,
    output logic              sdr_rd,
    output logic              sdr_wr,
    output logic [ADDR_W-1:0] sdr_hAddr,
    output logic [15:0]       sdr_hDIn,
    input  logic              sdr_earlyOpBegun,
    input  logic              sdr_opBegun,
    input  logic              sdr_rdPending,
    input  logic              sdr_done,
    input  logic              sdr_rdDone,
    input  logic [15:0]       sdr_hDOut,
    output logic              underrun,
    output logic [15:0]       underrun_cnt
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fb_state_t         r_state, w_nxt_state, w_fresh;
    logic [ADDR_W-1:0] r_addr, r_remaining, r_lat_base, r_lat_words;
    logic [OUTS_W-1:0] r_outstanding, w_out_nxt;
    logic              r_abort, w_abort_nxt;
    logic [CW-1:0]     w_fifo_count;
    logic [31:0]       w_level;
    logic              w_can_issue, w_accept, w_pop, w_fifo_wr, w_flush;
    logic              w_load_in, w_load_lat, w_latch, w_active;
    logic              w_unused_mon;

    assign w_unused_mon = sdr_opBegun ^ sdr_rdPending ^ sdr_done;

    // Credit covers both buffered words and reads still in flight.
    assign w_level     = 32'(w_fifo_count) + 32'(r_outstanding);
    assign w_can_issue = (r_state == S_FETCH) && (r_remaining != '0) &&
                         (w_level < 32'(FIFO_DEPTH)) && (r_outstanding != '1);
    assign w_accept    = w_can_issue && sdr_earlyOpBegun;
    assign w_active    = (r_state == S_FETCH) || (r_state == S_DONE);

    assign sdr_rd    = w_can_issue;
    assign sdr_hAddr = r_addr;
    assign sdr_wr    = 1'b0;
    assign sdr_hDIn  = '0;

    assign px_valid  = (w_fifo_count != '0);
    assign w_pop     = px_valid && px_ready;
    assign w_fifo_wr = sdr_rdDone && w_active && !w_flush;

    // Outstanding reads: accept adds, return removes, both together cancel.
    always_comb begin
        w_out_nxt = r_outstanding;
        case ({w_accept, sdr_rdDone})
            2'b10:   w_out_nxt = r_outstanding + 1'b1;
            2'b01:   w_out_nxt = (r_outstanding != '0) ? r_outstanding - 1'b1 : r_outstanding;
            default: w_out_nxt = r_outstanding;
        endcase
    end

    // Next-state: frame start / abort handling and drain through S_FLUSH.
    always_comb begin
        w_nxt_state = r_state;
        w_load_in   = 1'b0;
        w_load_lat  = 1'b0;
        w_latch     = 1'b0;
        w_flush     = 1'b0;
        w_abort_nxt = r_abort;
        w_fresh     = (fb_words == '0) ? S_DONE : S_FETCH;
        case (r_state)
            S_IDLE: begin
                if (enable && frame_start) begin
                    w_load_in   = 1'b1;
                    w_latch     = 1'b1;
                    w_nxt_state = w_fresh;
                end
            end
            S_FETCH, S_DONE: begin
                if (!enable) begin
                    w_flush     = 1'b1;
                    w_abort_nxt = (w_out_nxt != '0);
                    w_nxt_state = (w_out_nxt == '0) ? S_IDLE : S_FLUSH;
                end else if (frame_start) begin
                    w_flush     = 1'b1;
                    w_latch     = 1'b1;
                    w_abort_nxt = 1'b0;
                    if (w_out_nxt == '0) begin
                        w_load_in   = 1'b1;
                        w_nxt_state = w_fresh;
                    end else begin
                        w_nxt_state = S_FLUSH;
                    end
                end else if (r_state == S_FETCH &&
                             (r_remaining == '0 ||
                              (w_accept && r_remaining == ADDR_W'(1)))) begin
                    w_nxt_state = S_DONE;
                end
            end
            S_FLUSH: begin
                w_flush = 1'b1;
                if (!enable) begin
                    w_abort_nxt = 1'b1;
                end else if (frame_start) begin
                    w_latch     = 1'b1;
                    w_abort_nxt = 1'b0;
                end
                if (r_outstanding == '0) begin
                    w_abort_nxt = 1'b0;
                    if (!enable) begin
                        w_nxt_state = S_IDLE;
                    end else if (frame_start) begin
                        w_load_in   = 1'b1;
                        w_nxt_state = w_fresh;
                    end else if (r_abort) begin
                        w_nxt_state = S_IDLE;
                    end else begin
                        w_load_lat  = 1'b1;
                        w_nxt_state = (r_lat_words == '0) ? S_DONE : S_FETCH;
                    end
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    // State, counters and the frame parameters held across a flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_remaining   <= '0;
            r_outstanding <= '0;
            r_lat_base    <= '0;
            r_lat_words   <= '0;
            r_abort       <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_outstanding <= w_out_nxt;
            r_abort       <= w_abort_nxt;
            if (w_latch) begin
                r_lat_base  <= fb_base;
                r_lat_words <= fb_words;
            end
            if (w_load_in) begin
                r_addr      <= fb_base;
                r_remaining <= fb_words;
            end else if (w_load_lat) begin
                r_addr      <= r_lat_base;
                r_remaining <= r_lat_words;
            end else if (w_accept) begin
                r_addr      <= r_addr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
            end
        end
    end

    fb_line_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(16)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (w_flush),
        .wr_en   (w_fifo_wr),
        .wr_data (sdr_hDOut),
        .rd_en   (w_pop),
        .rd_data (px_data),
        .count   (w_fifo_count)
    );

`ifdef FB_READER_UNDERRUN_EN
    logic        r_underrun;
    logic [15:0] r_underrun_cnt;
    logic        w_urun_evt;

    assign w_urun_evt   = px_ready && !px_valid && w_active &&
                          ((r_outstanding != '0) || (r_remaining != '0));
    assign underrun     = r_underrun;
    assign underrun_cnt = r_underrun_cnt;

    // Sticky flag plus saturating count of empty pop attempts mid-frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_underrun     <= 1'b0;
            r_underrun_cnt <= '0;
        end else if (w_urun_evt) begin
            r_underrun <= 1'b1;
            if (r_underrun_cnt != FB_UNDERRUN_MAX)
                r_underrun_cnt <= r_underrun_cnt + 1'b1;
        end
    end
`else
    assign underrun     = 1'b0;
    assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_fb_sdram_reader.sv
// Scoreboard bench: SDRAM controller model with programmable latency,
// expected request addresses and pixels queued per frame.
module tb_fb_sdram_reader;

    logic        clk = 1'b0, reset = 1'b1, enable = 1'b1, frame_start = 1'b0;
    logic [21:0] fb_base = '0, fb_words = '0;
    logic [15:0] px_data;
    logic        px_valid, px_ready = 1'b0;
    logic        sdr_rd, sdr_wr;
    logic [21:0] sdr_hAddr;
    logic [15:0] sdr_hDIn;
    logic        sdr_earlyOpBegun = 1'b0, sdr_rdDone = 1'b0;
    logic        sdr_opBegun = 1'b0, sdr_rdPending = 1'b0, sdr_done = 1'b0;
    logic [15:0] sdr_hDOut = '0;
    logic        underrun;
    logic [15:0] underrun_cnt;

    always #5 clk = ~clk;

    fb_sdram_reader dut (
        .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start),
        .fb_base(fb_base), .fb_words(fb_words),
        .px_data(px_data), .px_valid(px_valid), .px_ready(px_ready),
        .sdr_rd(sdr_rd), .sdr_wr(sdr_wr), .sdr_hAddr(sdr_hAddr), .sdr_hDIn(sdr_hDIn),
        .sdr_earlyOpBegun(sdr_earlyOpBegun), .sdr_opBegun(sdr_opBegun),
        .sdr_rdPending(sdr_rdPending), .sdr_done(sdr_done),
        .sdr_rdDone(sdr_rdDone), .sdr_hDOut(sdr_hDOut),
        .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    int total = 0, bad = 0, cyc = 0;
    int lat = 3, early_mode = 1, rdy_mode = 1;
    bit urun_trk = 1'b0;
    logic [21:0] addr_q[$];
    logic [15:0] px_q[$];
    logic [21:0] pipe_a[$];
    int          pipe_d[$];
    int fs_cyc = 0, f_words = 0, first_acc = -1, first_ret = -1, first_vld = -1;
    int acc_cnt = 0, pop_cnt = 0, rd_seen = 0, m_rets = 0, m_pops = 0, m_ucnt = 0;
    bit          pend = 1'b0;
    logic [21:0] pend_a = '0;

    // Memory image of the SDRAM as seen by the reader.
    function automatic logic [15:0] memv(logic [21:0] a);
        return a[15:0] ^ 16'h5A3C ^ {a[21:16], a[21:12]};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Controller model, request checker and pixel monitor.
    always @(negedge clk) begin
        bit          e, rdy, ret_now, mv;
        logic [21:0] a;
        cyc++;
        case (early_mode)
            0:       e = 1'b0;
            1:       e = 1'b1;
            default: e = ($urandom_range(0, 3) != 0);
        endcase
        case (rdy_mode)
            0:       rdy = 1'b0;
            1:       rdy = 1'b1;
            default: rdy = 1'($urandom_range(0, 1));
        endcase
        sdr_earlyOpBegun = e;
        px_ready = rdy;
        if (sdr_rd) rd_seen++;
        if (pend) begin
            chk("hold_rd", 32'(sdr_rd), 32'd1);
            chk("hold_addr", 32'(sdr_hAddr), 32'(pend_a));
        end
        pend   = sdr_rd && !e && enable && !frame_start;
        pend_a = sdr_hAddr;
        if (sdr_rd && e) begin
            chk("outs_limit", 32'(pipe_a.size() < 7), 32'd1);
            if (addr_q.size() == 0) begin
                total++; bad++;
                $display("FAIL extra_req actual=%0h expected=none", sdr_hAddr);
            end else begin
                chk("req_addr", 32'(sdr_hAddr), 32'(addr_q.pop_front()));
            end
            pipe_a.push_back(sdr_hAddr);
            pipe_d.push_back(cyc + lat);
            acc_cnt++;
            if (first_acc < 0) first_acc = cyc;
            chk("credit", 32'((acc_cnt - pop_cnt) <= 64), 32'd1);
        end
        mv = (m_rets - m_pops) > 0;
        if (urun_trk) begin
            chk("urun_vld_model", 32'(px_valid), 32'(mv));
            if (cyc > fs_cyc && m_rets < f_words && !mv && rdy) m_ucnt++;
        end
        if (px_valid && first_vld < 0) first_vld = cyc;
        if (px_valid && rdy) begin
            pop_cnt++;
            m_pops++;
            if (px_q.size() == 0) begin
                total++; bad++;
                $display("FAIL extra_px actual=%0h expected=none", px_data);
            end else begin
                chk("px_data", 32'(px_data), 32'(px_q.pop_front()));
            end
        end
        ret_now = 1'b0;
        if (pipe_d.size() > 0 && pipe_d[0] == cyc) begin
            a = pipe_a.pop_front();
            void'(pipe_d.pop_front());
            sdr_rdDone = 1'b1;
            sdr_hDOut  = memv(a);
            ret_now    = 1'b1;
            if (first_ret < 0) first_ret = cyc;
        end else begin
            sdr_rdDone = 1'b0;
            sdr_hDOut  = 16'h0;
        end
        if (ret_now) m_rets++;
        if (!enable) begin
            addr_q.delete();
            px_q.delete();
        end else if (frame_start) begin
            addr_q.delete();
            px_q.delete();
            for (int i = 0; i < int'(fb_words); i++) begin
                a = fb_base + 22'(i);
                addr_q.push_back(a);
                px_q.push_back(memv(a));
            end
            fs_cyc = cyc; f_words = int'(fb_words);
            first_acc = -1; first_ret = -1; first_vld = -1;
            acc_cnt = 0; pop_cnt = 0; m_rets = 0; m_pops = 0;
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_frame(logic [21:0] base, logic [21:0] words);
        @(posedge clk); #1;
        frame_start = 1'b1; fb_base = base; fb_words = words;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_drain(string nm);
        for (int i = 0; i < 4000 && (addr_q.size() + px_q.size() + pipe_a.size()) > 0; i++)
            @(posedge clk);
        chk(nm, 32'(addr_q.size() + px_q.size() + pipe_a.size()), 32'd0);
        step(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step(3);
        reset = 1'b0;
        @(negedge clk); #1;
        chk("rst_rd", 32'(sdr_rd), 32'd0);
        chk("rst_addr", 32'(sdr_hAddr), 32'd0);
        chk("rst_valid", 32'(px_valid), 32'd0);
        chk("rst_data", 32'(px_data), 32'd0);
        chk("rst_urun", 32'(underrun), 32'd0);
        chk("rst_ucnt", 32'(underrun_cnt), 32'd0);
        chk("rst_wr", 32'(sdr_wr), 32'd0);

        // Long read latency with an always-ready consumer.
        lat = 10; early_mode = 1; rdy_mode = 1; urun_trk = 1'b1;
        start_frame(22'h40, 22'd6);
        wait_drain("urun_drain");
        step(3);
        urun_trk = 1'b0;
`ifdef FB_READER_UNDERRUN_EN
        chk("underrun_flag", 32'(underrun), 32'(m_ucnt != 0));
        chk("underrun_cnt", 32'(underrun_cnt), 32'(m_ucnt));
`else
        chk("underrun_flag", 32'(underrun), 32'd0);
        chk("underrun_cnt", 32'(underrun_cnt), 32'd0);
`endif

        // Basic frame with latency checks.
        lat = 3;
        start_frame(22'h100, 22'd8);
        wait_drain("basic_drain");
        chk("first_rd_lat", 32'(first_acc - fs_cyc), 32'd1);
        chk("first_px_lat", 32'(first_vld - first_ret), 32'd1);
        rd_seen = 0;
        step(10);
        chk("done_no_rd", 32'(rd_seen), 32'd0);

        // Accept withheld for a few cycles.
        early_mode = 0;
        start_frame(22'h2000, 22'd5);
        step(5);
        early_mode = 1;
        wait_drain("stall_drain");

        // Consumer backpressure against the credit limit.
        rdy_mode = 0;
        start_frame(22'h1000, 22'd200);
        step(300);
        chk("bp_accepts", 32'(acc_cnt), 32'd64);
        chk("bp_valid", 32'(px_valid), 32'd1);
        rdy_mode = 1;
        wait_drain("bp_drain");

        // Restart with reads in flight.
        lat = 8; rdy_mode = 0;
        start_frame(22'h3000, 22'd20);
        step(4);
        start_frame(22'h5000, 22'd6);
        rdy_mode = 1;
        wait_drain("restart_drain");

        // Address wrap and empty frame.
        lat = 2;
        start_frame(22'h3FFFFE, 22'd4);
        wait_drain("wrap_drain");
        rd_seen = 0;
        start_frame(22'h77, 22'd0);
        step(20);
        chk("zero_rd", 32'(rd_seen), 32'd0);
        chk("zero_valid", 32'(px_valid), 32'd0);

        // Abort via enable.
        lat = 5;
        start_frame(22'h9000, 22'd30);
        step(4);
        enable = 1'b0;
        step(2);
        rd_seen = 0;
        step(20);
        chk("abort_rd", 32'(rd_seen), 32'd0);
        chk("abort_valid", 32'(px_valid), 32'd0);
        enable = 1'b1;
        step(2);

        // Randomized frames, odd ones restarted mid-flight.
        for (int k = 0; k < 6; k++) begin
            lat = $urandom_range(1, 6);
            early_mode = 2; rdy_mode = 2;
            start_frame(22'($urandom), 22'($urandom_range(1, 40)));
            if (k % 2 == 1) begin
                step($urandom_range(0, 12));
                start_frame(22'($urandom), 22'($urandom_range(1, 40)));
            end
            wait_drain("rand_drain");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
